// File: rtl/mips_wb_trace.sv
// Writeback trace FIFO: records every register-file write the core performs
// (timestamp, destination register, data) for a host to drain. Overflow is
// sticky and dropped writebacks are counted with saturation.
module mips_wb_trace #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_ts,
  output logic [4:0]               rd_reg,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [4:0]        rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TS_W-1:0] ts;
  logic            push_req, push, pop, drop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // r0 writes are architectural no-ops, so they never enter the trace.
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    push_req = wb_valid && (wb_reg != 5'd0);
    pop      = rd_en && !empty;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Free-running timestamp; deliberately untouched by clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  // Trace storage; needs no reset since occupancy governs what is readable.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= '{ts: ts, rg: wb_reg, data: wb_data};
  end

  // Pointers and occupancy; clear discards any same-cycle push or pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overflow bookkeeping: sticky flag plus saturating drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Registered read port; payload holds its last value when nothing is popped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_ts    <= '0;
      rd_reg   <= '0;
      rd_data  <= '0;
    end else if (clear) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_ts   <= mem[rd_ptr].ts;
        rd_reg  <= mem[rd_ptr].rg;
        rd_data <= mem[rd_ptr].data;
      end
    end
  end
endmodule
